// File: rtl/fma_vec_runner_if.sv
// Load port between the host and fma_vec_runner: one operand/expected-result
// vector per accepted beat.
interface fma_vec_runner_if #(
   parameter int WIDTH = 64,
   parameter int LANES = 4
);
   logic                     ld_valid;
   logic                     ld_ready;
   logic [LANES*WIDTH-1:0]   ld_a;
   logic [LANES*WIDTH-1:0]   ld_b;
   logic [LANES*WIDTH-1:0]   ld_c;
   logic [LANES*WIDTH-1:0]   ld_exp;

   modport master (
      output ld_valid, ld_a, ld_b, ld_c, ld_exp,
      input  ld_ready
   );

   modport slave (
      input  ld_valid, ld_a, ld_b, ld_c, ld_exp,
      output ld_ready
   );
endinterface

// File: rtl/fma_vec_runner.sv
// Vector engine for the multi-lane FMA: buffers vectors, issues them back to
// back into a fixed-latency FMA and checks every lane against expected data.
module fma_vec_runner #(
   parameter int WIDTH = 64,
   parameter int LANES = 4,
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int LAT   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   fma_vec_runner_if.slave        ld,
   input  logic [LANES-1:0]       lane_en,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   clear,
   output logic [LANES*WIDTH-1:0] dut_a,
   output logic [LANES*WIDTH-1:0] dut_b,
   output logic [LANES*WIDTH-1:0] dut_c,
   output logic                   dut_valid,
   input  logic [LANES*WIDTH-1:0] dut_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [15:0]            err_count,
   output logic [AW-1:0]          first_err_idx,
   output logic [LANES-1:0]       err_lanes,
   output logic [AW:0]            vec_count
);
   localparam int VW = LANES * WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [VW-1:0]    mem_a   [DEPTH];
   logic [VW-1:0]    mem_b   [DEPTH];
   logic [VW-1:0]    mem_c   [DEPTH];
   logic [VW-1:0]    mem_exp [DEPTH];
   logic [AW-1:0]    issue_idx;
   logic             pipe_v   [LAT];
   logic [AW-1:0]    pipe_idx [LAT];

   logic             idle_or_done;
   logic             do_abort;
   logic             do_clear;
   logic             do_start;
   logic             do_load;
   logic             last_issue;
   logic             pipe_pending;
   logic             cmp_v;
   logic [AW-1:0]    cmp_idx;
   logic [VW-1:0]    exp_sel;
   logic [LANES-1:0] mismatch;

   // Priority abort > clear > start > load; each only acts in its own states.
   always_comb begin
      idle_or_done = (state == S_IDLE) || (state == S_DONE);
      do_abort     = abort && !idle_or_done;
      do_clear     = clear && idle_or_done;
      do_start     = start && idle_or_done && !clear && (vec_count != '0);
      ld.ld_ready  = (state == S_IDLE) && (vec_count < (AW+1)'(DEPTH));
      do_load      = ld.ld_valid && ld.ld_ready && !clear && !do_start;
      last_issue   = (({1'b0, issue_idx}) + (AW+1)'(1)) == vec_count;
   end

   always_comb begin
      dut_valid = (state == S_RUN);
      dut_a     = '0;
      dut_b     = '0;
      dut_c     = '0;
      if (dut_valid) begin
         dut_a = mem_a[issue_idx];
         dut_b = mem_b[issue_idx];
         dut_c = mem_c[issue_idx];
      end
   end

   // The entry in the last stage is compared this cycle, so it does not
   // keep DRAIN alive; done then rises the cycle after the final compare.
   always_comb begin
      pipe_pending = 1'b0;
      for (int unsigned i = 0; i + 1 < unsigned'(LAT); i++)
         pipe_pending = pipe_pending | pipe_v[i];
   end

   always_comb begin
      cmp_v    = pipe_v[LAT-1];
      cmp_idx  = pipe_idx[LAT-1];
      exp_sel  = mem_exp[cmp_idx];
      mismatch = '0;
      for (int unsigned i = 0; i < unsigned'(LANES); i++)
         mismatch[i] = lane_en[i] &&
                       (dut_out[i*WIDTH +: WIDTH] != exp_sel[i*WIDTH +: WIDTH]);
   end

   always_ff @(posedge clk) begin
      if (do_load) begin
         mem_a[vec_count[AW-1:0]]   <= ld.ld_a;
         mem_b[vec_count[AW-1:0]]   <= ld.ld_b;
         mem_c[vec_count[AW-1:0]]   <= ld.ld_c;
         mem_exp[vec_count[AW-1:0]] <= ld.ld_exp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         vec_count     <= '0;
         issue_idx     <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         err_lanes     <= '0;
         for (int unsigned i = 0; i < unsigned'(LAT); i++) begin
            pipe_v[i]   <= 1'b0;
            pipe_idx[i] <= '0;
         end
      end else begin
         pipe_v[0]   <= dut_valid && !do_abort;
         pipe_idx[0] <= issue_idx;
         for (int unsigned i = 1; i < unsigned'(LAT); i++) begin
            pipe_v[i]   <= pipe_v[i-1] && !do_abort;
            pipe_idx[i] <= pipe_idx[i-1];
         end

         if (cmp_v && (mismatch != '0)) begin
            if (err_count != '1)
               err_count <= err_count + 16'd1;
            if (err_count == '0)
               first_err_idx <= cmp_idx;
            err_lanes <= err_lanes | mismatch;
         end

         if (do_abort) begin
            state <= S_IDLE;
         end else if (do_clear) begin
            state     <= S_IDLE;
            vec_count <= '0;
         end else if (do_start) begin
            state         <= S_RUN;
            issue_idx     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_lanes     <= '0;
         end else begin
            case (state)
               S_IDLE: if (do_load) vec_count <= vec_count + (AW+1)'(1);
               S_RUN: begin
                  issue_idx <= issue_idx + AW'(1);
                  if (last_issue)
                     state <= S_DRAIN;
               end
               S_DRAIN: if (!pipe_pending) state <= S_DONE;
               default: ;
            endcase
         end
      end
   end

   assign busy = (state == S_RUN) || (state == S_DRAIN);
   assign done = (state == S_DONE);
   assign pass = done && (err_count == '0);
endmodule

// File: tb/tb_fma_vec_runner.sv
// Self-checking bench for fma_vec_runner: behavioural LAT-cycle FMA, issue
// scoreboard, table-driven runs and hand-written corner sequences.
module tb_fma_vec_runner;
   localparam int WIDTH = 64;
   localparam int LANES = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int LAT   = 3;
   localparam int VW    = LANES * WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic [LANES-1:0] lane_en;
   logic             start, abort, clear;
   logic [VW-1:0]    dut_a, dut_b, dut_c, dut_out;
   logic             dut_valid, busy, done, pass;
   logic [15:0]      err_count;
   logic [AW-1:0]    first_err_idx;
   logic [LANES-1:0] err_lanes;
   logic [AW:0]      vec_count;

   fma_vec_runner_if #(.WIDTH(WIDTH), .LANES(LANES)) ld_if ();

   fma_vec_runner #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .ld(ld_if), .lane_en(lane_en),
      .start(start), .abort(abort), .clear(clear),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_valid(dut_valid),
      .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_idx(first_err_idx),
      .err_lanes(err_lanes), .vec_count(vec_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Behavioural FMA with LAT cycles of latency
   function automatic logic [63:0] fma64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      return $realtobits($bitstoreal(a) * $bitstoreal(b) + $bitstoreal(c));
   endfunction

   logic [VW-1:0] fpipe [LAT];
   always @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         fpipe[0][i*WIDTH +: WIDTH] <= fma64(dut_a[i*WIDTH +: WIDTH], dut_b[i*WIDTH +: WIDTH],
                                             dut_c[i*WIDTH +: WIDTH]);
      for (int s = 1; s < LAT; s++)
         fpipe[s] <= fpipe[s-1];
   end
   assign dut_out = fpipe[LAT-1];

   typedef struct {
      logic [VW-1:0] a, b, c;
   } iss_t;
   iss_t sb_q[$];

   logic [VW-1:0] ma [DEPTH];
   logic [VW-1:0] mb [DEPTH];
   logic [VW-1:0] mc [DEPTH];
   logic [VW-1:0] me [DEPTH];

   always @(negedge clk) begin
      if (!rst) begin
         if (dut_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue actual=%0h required=none", dut_a);
            end else begin
               iss_t e;
               e = sb_q.pop_front();
               chk("issue_a", dut_a, e.a);
               chk("issue_b", dut_b, e.b);
               chk("issue_c", dut_c, e.c);
            end
         end else begin
            chk("idle_ops_zero", dut_a | dut_b | dut_c, '0);
         end
      end
   end

   typedef struct {
      int               n, pat, ck, cn, cl;
      logic [LANES-1:0] en;
      int               e_err, e_first;
      logic [LANES-1:0] e_lanes;
      logic             e_pass;
   } vec_t;
   vec_t tbl [6];

   task automatic chk_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_first_err", first_err_idx, 0);
      chk("rst_err_lanes", err_lanes, 0);
      chk("rst_vec_count", vec_count, 0);
      chk("rst_ld_ready", ld_if.ld_ready, 1);
      chk("rst_dut_valid", dut_valid, 0);
      chk("rst_dut_a", dut_a, 0);
   endtask

   // Vectors ck..ck+cn-1 get one expected lane corrupted, lane rotating from cl.
   task automatic load_vecs(input int n, input int pat, input int ck, input int cn, input int cl);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < LANES; i++) begin
            real ra, rb, rc;
            if (pat == 0) begin
               ra = 2.0; rb = 3.0; rc = 1.0;
               me[k][i*WIDTH +: WIDTH] = 64'h401C000000000000;
            end else begin
               ra = real'(k + 1); rb = real'(i + 2); rc = 0.5;
               me[k][i*WIDTH +: WIDTH] = $realtobits(ra * rb + rc);
            end
            ma[k][i*WIDTH +: WIDTH] = $realtobits(ra);
            mb[k][i*WIDTH +: WIDTH] = $realtobits(rb);
            mc[k][i*WIDTH +: WIDTH] = $realtobits(rc);
         end
         if (k >= ck && k < ck + cn) begin
            int ln;
            ln = (cl + k - ck) % LANES;
            me[k][ln*WIDTH +: WIDTH] = me[k][ln*WIDTH +: WIDTH] ^ 64'h1;
         end
         @(negedge clk);
         ld_if.ld_valid = 1'b1;
         ld_if.ld_a = ma[k]; ld_if.ld_b = mb[k]; ld_if.ld_c = mc[k]; ld_if.ld_exp = me[k];
         #1 chk("ld_ready_open", ld_if.ld_ready, 1);
      end
      @(negedge clk);
      ld_if.ld_valid = 1'b0;
      #1 chk("vec_count_loaded", vec_count, n);
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      #1 chk("clear_vec_count", vec_count, 0);
   endtask

   task automatic chk_result(input int e_err, input int e_first, input logic [LANES-1:0] e_lanes, input logic e_pass);
      chk("res_err_count", err_count, e_err);
      chk("res_first_err", first_err_idx, e_first);
      chk("res_err_lanes", err_lanes, e_lanes);
      chk("res_pass", pass, e_pass);
      chk("res_busy", busy, 0);
   endtask

   task automatic run_vec(input int n, input int abort_at, input int restart_at, input int rst_at);
      int cnt, nval, first_v, last_v;
      bit fin;
      for (int k = 0; k < n; k++) sb_q.push_back('{a: ma[k], b: mb[k], c: mc[k]});
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 1; nval = 0; first_v = 0; last_v = 0; fin = 1'b0;
      while (!fin && cnt < 200) begin
         #1;
         if (dut_valid) begin
            nval++;
            if (first_v == 0) first_v = cnt;
            last_v = cnt;
         end
         if (done) begin
            fin = 1'b1;
         end else if (cnt == abort_at) begin
            abort = 1'b1;
            @(negedge clk); abort = 1'b0;
            #1;
            chk("abort_dut_valid", dut_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_vec_count", vec_count, n);
            chk("abort_pending", sb_q.size(), n - abort_at);
            sb_q.delete();
            return;
         end else if (cnt == rst_at) begin
            rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            #1;
            chk_reset();
            chk("rst_pending", sb_q.size(), 0);
            sb_q.delete();
            return;
         end else begin
            if (cnt == restart_at) start = 1'b1;
            @(negedge clk); start = 1'b0;
            cnt++;
         end
      end
      chk("done_seen", fin, 1);
      chk("run_latency", cnt, n + LAT + 1);
      chk("issue_count", nval, n);
      chk("first_issue", first_v, 1);
      chk("last_issue", last_v, n);
      chk("sb_drained", sb_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{n: 3,  pat: 0, ck: -1, cn: 0, cl: 0, en: 4'b1111, e_err: 0, e_first: 0, e_lanes: 4'b0000, e_pass: 1};
      tbl[1] = '{n: 3,  pat: 0, ck: 1,  cn: 1, cl: 2, en: 4'b1111, e_err: 1, e_first: 1, e_lanes: 4'b0100, e_pass: 0};
      tbl[2] = '{n: 3,  pat: 0, ck: 1,  cn: 1, cl: 2, en: 4'b1011, e_err: 0, e_first: 0, e_lanes: 4'b0000, e_pass: 1};
      tbl[3] = '{n: 5,  pat: 1, ck: 1,  cn: 3, cl: 0, en: 4'b1111, e_err: 3, e_first: 1, e_lanes: 4'b0111, e_pass: 0};
      tbl[4] = '{n: 16, pat: 1, ck: -1, cn: 0, cl: 0, en: 4'b1111, e_err: 0, e_first: 0, e_lanes: 4'b0000, e_pass: 1};
      tbl[5] = '{n: 4,  pat: 1, ck: 0,  cn: 4, cl: 3, en: 4'b0000, e_err: 0, e_first: 0, e_lanes: 4'b0000, e_pass: 1};

      rst = 1'b1; start = 1'b0; abort = 1'b0; clear = 1'b0; lane_en = '1;
      ld_if.ld_valid = 1'b0; ld_if.ld_a = '0; ld_if.ld_b = '0; ld_if.ld_c = '0; ld_if.ld_exp = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 chk_reset();

      foreach (tbl[t]) begin
         do_clear();
         lane_en = tbl[t].en;
         load_vecs(tbl[t].n, tbl[t].pat, tbl[t].ck, tbl[t].cn, tbl[t].cl);
         if (tbl[t].n == DEPTH) begin
            chk("full_ld_ready", ld_if.ld_ready, 0);
            @(negedge clk);
            ld_if.ld_valid = 1'b1; ld_if.ld_a = '1; ld_if.ld_exp = '1;
            @(negedge clk);
            ld_if.ld_valid = 1'b0;
            #1 chk("full_vec_count", vec_count, DEPTH);
         end
         run_vec(tbl[t].n, -1, -1, -1);
         chk_result(tbl[t].e_err, tbl[t].e_first, tbl[t].e_lanes, tbl[t].e_pass);
      end

      // start with an empty buffer stays idle
      do_clear();
      lane_en = '1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("empty_start_busy", busy, 0);
         chk("empty_start_done", done, 0);
         @(negedge clk);
      end

      // start during RUN is ignored
      load_vecs(4, 1, -1, 0, 0);
      run_vec(4, -1, 2, -1);
      chk_result(0, 0, '0, 1);

      // abort on the second issue cycle, then a full rerun
      run_vec(4, 2, -1, -1);
      run_vec(4, -1, -1, -1);
      chk_result(0, 0, '0, 1);

      // reset in DRAIN after one error has been recorded
      do_clear();
      load_vecs(3, 0, 0, 1, 1);
      run_vec(3, -1, -1, 5);

      // clear beats start in DONE
      load_vecs(2, 0, -1, 0, 0);
      run_vec(2, -1, -1, -1);
      chk_result(0, 0, '0, 1);
      @(negedge clk); clear = 1'b1; start = 1'b1;
      @(negedge clk); clear = 1'b0; start = 1'b0;
      #1 chk("clr_start_vec_count", vec_count, 0);
      chk("clr_start_done", done, 0);
      chk("clr_start_busy", busy, 0);
      @(negedge clk);
      #1 chk("clr_start_no_issue", dut_valid, 0);
      chk("clr_start_ld_ready", ld_if.ld_ready, 1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
